// File: rtl/snooze_controller.sv
// ---------------------------------------------------------------------------
// snooze_controller
//
// Sits beside an alarm clock core and decides what happens while the alarm
// rings: snooze (reprogram the alarm a few minutes later), dismiss (stop it
// and put the original alarm time back), or act automatically when nobody
// attends the ringing for too long.
//
// Parameters
//   SNOOZE_MIN    snooze interval in minutes (1..59)
//   MAX_SNOOZE    consecutive snoozes allowed per alarm event (1..7)
//   RING_TIMEOUT  seconds of unattended ringing before automatic action (2..255)
//
// Ports
//   clock_1s      in   1 Hz timebase, all state updates on its rising edge
//   reset         in   asynchronous, active-high
//   alarm         in   ringing indication from the core
//   snooze_btn    in   snooze button level
//   dismiss_btn   in   dismiss button level
//   cur_hour1/0, cur_min1/0   in   current time, BCD
//   stop_alarm    out  one-cycle pulse to the core's alarm stop input
//   load_alarm    out  one-cycle pulse to the core's alarm load input
//   alm_hour1/0, alm_min1/0   out  alarm time to load, BCD, held between loads
//   snooze_count  out  snoozes taken during the current alarm event
//   state         out  0 IDLE, 1 RING, 2 CLEAR
//   timed_out     out  sticky flag, set when the ring timeout fires
// ---------------------------------------------------------------------------
module snooze_controller #(
   parameter int SNOOZE_MIN   = 5,
   parameter int MAX_SNOOZE   = 3,
   parameter int RING_TIMEOUT = 60
) (
   input  logic       clock_1s,
   input  logic       reset,
   input  logic       alarm,
   input  logic       snooze_btn,
   input  logic       dismiss_btn,
   input  logic [1:0] cur_hour1,
   input  logic [3:0] cur_hour0,
   input  logic [3:0] cur_min1,
   input  logic [3:0] cur_min0,
   output logic       stop_alarm,
   output logic       load_alarm,
   output logic [1:0] alm_hour1,
   output logic [3:0] alm_hour0,
   output logic [3:0] alm_min1,
   output logic [3:0] alm_min0,
   output logic [2:0] snooze_count,
   output logic [1:0] state,
   output logic       timed_out
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RING  = 2'd1,
      CLEAR = 2'd2,
      BAD   = 2'd3
   } state_t;

   localparam logic [6:0] SNOOZE_M7 = 7'(SNOOZE_MIN);
   localparam logic [2:0] MAX_CNT   = 3'(MAX_SNOOZE);
   localparam logic [7:0] RING_LAST = 8'(RING_TIMEOUT - 1);

   state_t     state_q, state_d;
   logic [7:0] ring_cnt, ring_cnt_d;
   logic [2:0] snooze_cnt_d;
   logic       timed_out_d;
   logic       stop_d, load_d;
   logic [1:0] alm_hour1_d;
   logic [3:0] alm_hour0_d, alm_min1_d, alm_min0_d;

   // Original alarm time, remembered at the first ring of an alarm event so
   // that a dismiss after snoozing can put the alarm back where it was.
   logic [1:0] orig_hour1, orig_hour1_d;
   logic [3:0] orig_hour0, orig_hour0_d, orig_min1, orig_min1_d, orig_min0, orig_min0_d;

   // Snooze target time (current time + SNOOZE_MIN), BCD.
   logic [6:0] min_sum, min_wrap, min_tens, min_ones;
   logic [5:0] hour_sum, hour_wrap, hour_tens, hour_ones;
   logic       hour_carry;
   logic [1:0] snz_hour1;
   logic [3:0] snz_hour0, snz_min1, snz_min0;

   logic       go_snooze, go_dismiss, go_ext;

   assign state = state_q;

   // Snooze arithmetic: convert BCD to binary minutes and hours, add the
   // interval with a carry into the hour, wrap at midnight, and split back
   // into BCD digits.
   always_comb begin
      min_sum    = {3'b000, cur_min1} * 7'd10 + {3'b000, cur_min0} + SNOOZE_M7;
      hour_carry = 1'b0;
      min_wrap   = min_sum;
      if (min_sum >= 7'd60) begin
         min_wrap   = min_sum - 7'd60;
         hour_carry = 1'b1;
      end
      hour_sum  = {4'b0000, cur_hour1} * 6'd10 + {2'b00, cur_hour0} + {5'b00000, hour_carry};
      hour_wrap = (hour_sum == 6'd24) ? 6'd0 : hour_sum;
      min_tens  = min_wrap / 7'd10;
      min_ones  = min_wrap - min_tens * 7'd10;
      hour_tens = hour_wrap / 6'd10;
      hour_ones = hour_wrap - hour_tens * 6'd10;
      snz_min1  = 4'(min_tens);
      snz_min0  = 4'(min_ones);
      snz_hour1 = 2'(hour_tens);
      snz_hour0 = 4'(hour_ones);
   end

   // State register plus every registered output. Pulses and alarm digits
   // are registered so the core sees clean, glitch-free load/stop strobes.
   always_ff @(posedge clock_1s or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         ring_cnt     <= 8'd0;
         snooze_count <= 3'd0;
         timed_out    <= 1'b0;
         stop_alarm   <= 1'b0;
         load_alarm   <= 1'b0;
         alm_hour1    <= 2'd2;
         alm_hour0    <= 4'd4;
         alm_min1     <= 4'd0;
         alm_min0     <= 4'd0;
         orig_hour1   <= 2'd2;
         orig_hour0   <= 4'd4;
         orig_min1    <= 4'd0;
         orig_min0    <= 4'd0;
      end else begin
         state_q      <= state_d;
         ring_cnt     <= ring_cnt_d;
         snooze_count <= snooze_cnt_d;
         timed_out    <= timed_out_d;
         stop_alarm   <= stop_d;
         load_alarm   <= load_d;
         alm_hour1    <= alm_hour1_d;
         alm_hour0    <= alm_hour0_d;
         alm_min1     <= alm_min1_d;
         alm_min0     <= alm_min0_d;
         orig_hour1   <= orig_hour1_d;
         orig_hour0   <= orig_hour0_d;
         orig_min1    <= orig_min1_d;
         orig_min0    <= orig_min0_d;
      end
   end

   // Next-state and next-output logic. In RING the decision is ranked:
   // dismiss, then snooze, then the core stopping the alarm on its own, then
   // the ring timeout. A snooze or timeout with no snoozes left degrades to a
   // dismiss so the user is never left without an alarm stop.
   always_comb begin
      state_d      = state_q;
      ring_cnt_d   = ring_cnt;
      snooze_cnt_d = snooze_count;
      timed_out_d  = timed_out;
      stop_d       = 1'b0;
      load_d       = 1'b0;
      alm_hour1_d  = alm_hour1;
      alm_hour0_d  = alm_hour0;
      alm_min1_d   = alm_min1;
      alm_min0_d   = alm_min0;
      orig_hour1_d = orig_hour1;
      orig_hour0_d = orig_hour0;
      orig_min1_d  = orig_min1;
      orig_min0_d  = orig_min0;
      go_snooze    = 1'b0;
      go_dismiss   = 1'b0;
      go_ext       = 1'b0;

      case (state_q)
         IDLE: begin
            if (dismiss_btn) begin
               timed_out_d = 1'b0;
            end
            if (alarm) begin
               state_d    = RING;
               ring_cnt_d = 8'd0;
               // Only the first ring of an event is the user's real alarm time.
               if (snooze_count == 3'd0) begin
                  orig_hour1_d = cur_hour1;
                  orig_hour0_d = cur_hour0;
                  orig_min1_d  = cur_min1;
                  orig_min0_d  = cur_min0;
               end
            end
         end

         RING: begin
            if (ring_cnt != RING_LAST) begin
               ring_cnt_d = ring_cnt + 8'd1;
            end

            if (dismiss_btn) begin
               go_dismiss = 1'b1;
            end else if (snooze_btn) begin
               if (snooze_count < MAX_CNT) go_snooze = 1'b1;
               else                        go_dismiss = 1'b1;
            end else if (!alarm) begin
               go_ext = 1'b1;
            end else if (ring_cnt == RING_LAST) begin
               timed_out_d = 1'b1;
               if (snooze_count < MAX_CNT) go_snooze = 1'b1;
               else                        go_dismiss = 1'b1;
            end

            if (go_snooze) begin
               state_d      = CLEAR;
               stop_d       = 1'b1;
               load_d       = 1'b1;
               snooze_cnt_d = snooze_count + 3'd1;
               alm_hour1_d  = snz_hour1;
               alm_hour0_d  = snz_hour0;
               alm_min1_d   = snz_min1;
               alm_min0_d   = snz_min0;
            end

            // Dismiss and external stop share the restore path; only the
            // stop pulse differs, since the core already stopped itself.
            if (go_dismiss || go_ext) begin
               state_d      = CLEAR;
               stop_d       = go_dismiss;
               snooze_cnt_d = 3'd0;
               if (snooze_count != 3'd0) begin
                  load_d      = 1'b1;
                  alm_hour1_d = orig_hour1;
                  alm_hour0_d = orig_hour0;
                  alm_min1_d  = orig_min1;
                  alm_min0_d  = orig_min0;
               end
            end
         end

         CLEAR: begin
            // Wait for the core to drop alarm so one ring is handled once.
            if (!alarm) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: doc/snooze_controller.md
SNOOZE_CONTROLLER -- requirements
Module: snooze_controller

Interface
REQ-001 Parameter SNOOZE_MIN, default 5, snooze interval in minutes, legal 1..59.
REQ-002 Parameter MAX_SNOOZE, default 3, maximum consecutive snoozes per alarm event, legal 1..7.
REQ-003 Parameter RING_TIMEOUT, default 60, seconds of unattended ringing before automatic action, legal 2..255.
REQ-004 clock_1s  in  1  1 Hz timebase; all state SHALL update on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high.
REQ-006 alarm  in  1  ringing indication from the alarm clock core.
REQ-007 snooze_btn  in  1  level, sampled on clock_1s.
REQ-008 dismiss_btn  in  1  level, sampled on clock_1s.
REQ-009 cur_hour1 in 2, cur_hour0 in 4, cur_min1 in 4, cur_min0 in 4  current BCD time from the core.
REQ-010 stop_alarm  out  1  registered one-cycle pulse to the core's alarm stop input.
REQ-011 load_alarm  out  1  registered one-cycle pulse to the core's alarm load input.
REQ-012 alm_hour1 out 2, alm_hour0 out 4, alm_min1 out 4, alm_min0 out 4  registered BCD alarm time; valid while load_alarm=1, held otherwise.
REQ-013 snooze_count  out  3  snoozes taken in current alarm event.
REQ-014 state  out  2  FSM state: 0 IDLE, 1 RING, 2 CLEAR.
REQ-015 timed_out  out  1  sticky flag, set when RING_TIMEOUT expires, cleared by dismiss_btn in IDLE or by reset.

Function
REQ-016 IDLE: alarm=1 SHALL go to RING and clear ring counter; if snooze_count=0, current time SHALL be captured into orig_h/orig_m.
REQ-017 RING: ring counter SHALL increment each cycle, saturating at RING_TIMEOUT-1.
REQ-018 RING, dismiss_btn=1 (priority over snooze_btn) SHALL pulse stop_alarm, go to CLEAR, clear snooze_count; if snooze_count was >0, SHALL also pulse load_alarm with orig time (restore).
REQ-019 RING, snooze_btn=1, dismiss_btn=0, snooze_count<MAX_SNOOZE SHALL pulse stop_alarm and load_alarm with current time + SNOOZE_MIN, increment snooze_count, go to CLEAR.
REQ-020 RING, snooze_btn=1 with snooze_count=MAX_SNOOZE SHALL be handled as dismiss (REQ-018).
REQ-021 RING, ring counter = RING_TIMEOUT-1 with no button SHALL set timed_out and act as snooze (REQ-019), or as dismiss if snooze_count=MAX_SNOOZE; buttons in the same cycle take priority.
REQ-022 RING, alarm falls to 0 without a button (external stop) SHALL go to CLEAR with no stop_alarm; restore load as in REQ-018 if snooze_count>0; snooze_count cleared.
REQ-023 CLEAR: outputs pulse-free; alarm=0 SHALL return to IDLE; alarm=1 SHALL remain in CLEAR.
REQ-024 Snooze arithmetic: m = 10*cur_min1 + cur_min0 + SNOOZE_MIN; m>=60 SHALL subtract 60 and carry 1 into hours; h = 10*cur_hour1 + cur_hour0 + carry; h=24 SHALL wrap to 0; result SHALL be converted back to BCD.
REQ-025 stop_alarm and load_alarm SHALL each be high for exactly one clock_1s cycle per event, never asserted in IDLE or CLEAR.
REQ-026 State encoding 3 SHALL be unreachable; if entered, SHALL go to IDLE next cycle.

Reset
REQ-027 On reset: state=IDLE, stop_alarm=0, load_alarm=0, alm digits=2,4,0,0, orig time=24:00, snooze_count=0, ring counter=0, timed_out=0.
REQ-028 Reset asserted mid-RING SHALL abort immediately with no pulse issued after release.

Verification
REQ-029 alarm rises at 07:30, snooze_btn at cycle 3 -> next cycle stop_alarm=1, load_alarm=1, alm=07:35, snooze_count=1, state=CLEAR.
REQ-030 cur time 23:58, snooze (SNOOZE_MIN=5) -> alm=00:03.
REQ-031 Three snoozes from 07:30, fourth ring with snooze_btn -> stop_alarm=1, load_alarm=1, alm=07:30, snooze_count=0.
REQ-032 alarm high 60 cycles, no buttons -> timed_out=1, load_alarm with +5 min, snooze_count=1.
REQ-033 snooze_btn and dismiss_btn both high in RING, snooze_count=0 -> stop_alarm=1, load_alarm=0, snooze_count=0.
REQ-034 reset pulse during RING at cycle 10 -> all outputs at REQ-027 values, state=IDLE, no later pulses until alarm re-rises.
